// File: rtl/tt_sweeper.sv
// Truth-table function block with registered direct evaluation and a self-characterisation sweep.
// Optional runtime-loadable table when TT_RUNTIME_LOAD_EN is defined.
module tt_sweeper #(
  parameter int unsigned             N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] TT     = 8'h31,
  parameter logic [(1<<N_IN)-1:0] EXPECT = TT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in,
  input  logic                   in_valid,
  output logic                   out,
  output logic                   out_valid,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  // 'table' is a reserved word, hence the prefix
  output logic [(1<<N_IN)-1:0]   tt_table,
  output logic                   pass
`ifdef TT_RUNTIME_LOAD_EN
  ,
  input  logic                   tt_load,
  input  logic [(1<<N_IN)-1:0]   tt_data
`endif
);

  localparam int unsigned W  = 1 << N_IN;
  localparam int unsigned IW = N_IN + 1;
  localparam logic [IW-1:0] IdxLast = IW'(W - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    table_q, table_d;
  logic            pass_q, pass_d;
  logic            out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    tt_eff;

`ifdef TT_RUNTIME_LOAD_EN
  logic [W-1:0] tt_q, tt_d;

  // A load only lands at the edge, so a same-cycle evaluation still sees the old table.
  always_comb begin
    tt_d = tt_q;
    if (state_q == StIdle && tt_load) begin
      tt_d = tt_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tt_q <= TT;
    end else begin
      tt_q <= tt_d;
    end
  end

  assign tt_eff = tt_q;
`else
  assign tt_eff = TT;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    table_d     = table_q;
    pass_d      = pass_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSweep;
          idx_d   = '0;
          table_d = '0;
          pass_d  = 1'b0;
        end else if (in_valid) begin
          out_d       = tt_eff[in];
          out_valid_d = 1'b1;
        end
      end
      StSweep: begin
        table_d[idx_q[N_IN-1:0]] = tt_eff[idx_q[N_IN-1:0]];
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          state_d = StDone;
          // Judge the final table now so pass is already valid alongside done.
          pass_d  = (table_d == EXPECT);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      table_q     <= '0;
      pass_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      table_q     <= table_d;
      pass_q      <= pass_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == StSweep);
  assign done      = (state_q == StDone);
  assign tt_table  = table_q;
  assign pass      = pass_q;

endmodule
